y_mux_arb: RTL and testbench
============================

Name: y_mux_arb

Overview:
- Parametrised N-channel, SIZE-bit registered multiplexer; successor to the combinational 4-to-1 word mux.
- Adds a valid/ready handshake per input, a one-entry output register, and two selection modes: fixed select and round-robin arbitration.
- Sits between multiple producers (register-file read ports, ALU result sources) and a single downstream consumer.

Parameters:
- SIZE, 32, data width in bits per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(CHANNELS), width of the select and channel-index fields; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*SIZE  packed channel data; channel i occupies bits [i*SIZE +: SIZE].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode; ignored in round-robin.
- out_data  output  SIZE  registered selected data.
- out_chan  output  SEL_W  registered index of the channel held in out_data.
- out_valid  output  1  output register holds valid data.
- out_ready  input  1  consumer accepts out_data this cycle.
- xfer_count  output  16  accepted-transfer count (see Optional Feature).

Behaviour:
- Reset, sampled on the clk edge while reset=1:
  - out_valid=0, out_data=0, out_chan=0, xfer_count=0.
  - Round-robin pointer last_grant = CHANNELS-1, so channel 0 has first priority.
  - Reset takes priority over every other event in the same cycle; any held data is discarded.
- can_accept = !out_valid || out_ready.
- Grant, combinational, one-hot or zero:
  - Fixed mode: grant[sel] = in_valid[sel]. If sel >= CHANNELS, no grant.
  - Round-robin mode: scan channels last_grant+1, last_grant+2, ... wrapping modulo CHANNELS. The first channel with in_valid=1 wins.
- in_ready[i] = grant[i] && can_accept. At most one in_ready is high per cycle. in_ready must not depend on in_valid of other channels when mode=0.
- Accept (acc) = |(grant) && can_accept. On the clk edge with acc:
  - out_data <= in_data of the granted channel.
  - out_chan <= granted index.
  - out_valid <= 1.
  - last_grant <= granted index, in both modes.
- Drain without refill (out_valid && out_ready && !acc): out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous drain and accept: new data is loaded with out_valid staying 1. This gives full throughput of one word per cycle.
- Stall (out_valid && !out_ready): out_data, out_chan and out_valid hold. All in_ready=0.
- Latency: one cycle from input handshake to out_valid.
- No valid inputs: no state change apart from a drain.
- Changing mode or sel mid-stream affects only the next arbitration; the held output is unaffected.
- Wrap-around: with last_grant = CHANNELS-1, the scan starts at channel 0.

Optional Feature:
- Macro: YMUX_ARB_COUNT_EN.
- Defined: xfer_count increments by 1 on every clk edge where out_valid && out_ready. It saturates at 16'hFFFF and clears on reset.
- Undefined: xfer_count is tied to 16'h0000 and no counter flops are built. The port list is identical in both builds.

Test Plan:
- Reset with all in_valid=4'b1111 and reset=1 for 2 cycles -> out_valid=0, out_data=0, in_ready=0000, xfer_count=0. First accept after reset release goes to channel 0.
- Fixed mode, sel=2, in_data ch2=32'hDEADBEEF, in_valid=4'b0100, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=DEADBEEF, out_chan=2, out_valid=1. With sel=1 and only ch2 valid, in_ready=0000.
- Round-robin, all channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles, out_valid held 1 throughout.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with ch1 valid -> out_data/out_chan stable and in_ready=0000. On out_ready=1, ch1 is accepted in the same cycle and appears next cycle.
- Sparse round-robin: last_grant=1, in_valid=4'b0001 -> scan order 2,3,0 grants ch0. Then with in_valid=4'b1001 the next grant is ch3, not ch0.
- With YMUX_ARB_COUNT_EN defined: 10 completed transfers -> xfer_count=10. Reset mid-stream -> xfer_count=0 and out_valid=0 on the next edge. Without the macro, xfer_count stays 0.

Source files
------------

// File: rtl/y_mux_arb_if.sv
// rtl/y_mux_arb_if.sv - handshake and data bundle between producers, y_mux_arb and its consumer
interface y_mux_arb_if #(
    parameter int SIZE     = 32,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*SIZE-1:0] in_data;
    logic [CHANNELS-1:0]      in_valid;
    logic [CHANNELS-1:0]      in_ready;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [SIZE-1:0]          out_data;
    logic [SEL_W-1:0]         out_chan;
    logic                     out_valid;
    logic                     out_ready;
    logic [15:0]              xfer_count;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid, xfer_count
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid, xfer_count
    );
endinterface

// File: rtl/y_mux_arb.sv
// rtl/y_mux_arb.sv - N-channel registered mux with fixed-select / round-robin arbitration
// Optional transfer counter enabled by defining YMUX_ARB_COUNT_EN.
module y_mux_arb #(
    parameter int SIZE     = 32,
    parameter int CHANNELS = 4
) (
    input  logic        clk,
    input  logic        reset,
    y_mux_arb_if.slave  bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [SEL_W-1:0]    last_grant;
    logic [SEL_W-1:0]    gidx;
    logic [SEL_W-1:0]    idx_s;
    logic [CHANNELS-1:0] grant;
    logic                any_grant;
    logic                can_accept;
    logic                acc;
    int                  idx;

    logic [SIZE-1:0]     out_data_r;
    logic [SEL_W-1:0]    out_chan_r;
    logic                out_valid_r;

    always_comb begin
        grant     = '0;
        gidx      = '0;
        any_grant = 1'b0;
        idx       = 0;
        idx_s     = '0;
        if (!bus.mode) begin
            if ((int'(bus.sel) < CHANNELS) && bus.in_valid[bus.sel]) begin
                grant[bus.sel] = 1'b1;
                gidx           = bus.sel;
                any_grant      = 1'b1;
            end
        end else begin
            // Scan starts one past the previous winner so every channel gets a turn.
            for (int k = 1; k <= CHANNELS; k++) begin
                idx   = (int'(last_grant) + k) % CHANNELS;
                idx_s = SEL_W'(idx);
                if (!any_grant && bus.in_valid[idx_s]) begin
                    grant[idx_s] = 1'b1;
                    gidx         = idx_s;
                    any_grant    = 1'b1;
                end
            end
        end
    end

    assign can_accept   = !out_valid_r || bus.out_ready;
    assign acc          = any_grant && can_accept && !reset;
    // Ready is masked during reset because anything accepted then would be discarded.
    assign bus.in_ready = grant & {CHANNELS{can_accept && !reset}};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
            last_grant  <= SEL_W'(CHANNELS - 1);
        end else if (acc) begin
            out_data_r  <= bus.in_data[int'(gidx)*SIZE +: SIZE];
            out_chan_r  <= gidx;
            out_valid_r <= 1'b1;
            last_grant  <= gidx;
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_chan  = out_chan_r;
    assign bus.out_valid = out_valid_r;

`ifdef YMUX_ARB_COUNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 16'h0000;
        end else if (out_valid_r && bus.out_ready && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'h0001;
        end
    end

    assign bus.xfer_count = cnt;
`else
    assign bus.xfer_count = 16'h0000;
`endif
endmodule

// File: tb/tb_y_mux_arb.sv
// tb/tb_y_mux_arb.sv - self-checking bench for y_mux_arb with a behavioural reference model
module tb_y_mux_arb;
    localparam int N = 4;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    y_mux_arb_if #(.SIZE(W), .CHANNELS(N)) bus ();

    y_mux_arb #(.SIZE(W), .CHANNELS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the output register should hold.
    logic          m_valid;
    logic [W-1:0]  m_data;
    int            m_chan;
    int            m_lg;
    int            m_cnt;

    function automatic int exp_grant();
        if (!bus.mode) begin
            if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
            return -1;
        end
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (m_lg + off) % N;
            if (bus.in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (reset || g < 0 || (m_valid && !bus.out_ready)) return '0;
        return N'(1 << g);
    endfunction

    task automatic model_update();
        int g;
        bit can;
        g   = exp_grant();
        can = !m_valid || bus.out_ready;
        if (reset) begin
            m_valid = 0; m_data = '0; m_chan = 0; m_lg = N - 1; m_cnt = 0;
        end else begin
`ifdef YMUX_ARB_COUNT_EN
            if (m_valid && bus.out_ready && m_cnt < 16'hFFFF) m_cnt++;
`endif
            if (g >= 0 && can) begin
                m_data  = bus.in_data[g*W +: W];
                m_chan  = g;
                m_valid = 1;
                m_lg    = g;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic md, input logic [1:0] s, input logic ordy);
        bus.in_valid  = v;
        bus.mode      = md;
        bus.sel       = s;
        bus.out_ready = ordy;
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = $urandom;
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive(4'b1111, 1'b1, 2'd0, 1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready got %b want 0000", bus.in_ready);
        end
        tick(); tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_chan !== 2'd0) begin
            errors++; $display("FAIL reset_outputs got v=%b d=%h c=%0d want 0/0/0",
                               bus.out_valid, bus.out_data, bus.out_chan);
        end
        checks++;
        if (bus.xfer_count !== 16'h0) begin
            errors++; $display("FAIL reset_count got %0d want 0", bus.xfer_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_ready got %b want 0001", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_chan !== 2'd0) begin
            errors++; $display("FAIL reset_first_grant got v=%b c=%0d want 1/0", bus.out_valid, bus.out_chan);
        end
    endtask

    task automatic test_fixed();
        do_reset(1);
        drive(4'b0100, 1'b0, 2'd2, 1'b1);
        bus.in_data[2*W +: W] = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0100) begin
            errors++; $display("FAIL fixed_ready got %b want 0100", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_data !== 32'hDEADBEEF || bus.out_chan !== 2'd2 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL fixed_out got d=%h c=%0d v=%b want DEADBEEF/2/1",
                               bus.out_data, bus.out_chan, bus.out_valid);
        end
        bus.sel = 2'd1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0000) begin
            errors++; $display("FAIL fixed_wrong_sel got %b want 0000", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL fixed_drain got v=%b d=%h want 0/DEADBEEF", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_round_robin();
        int want [6] = '{0, 1, 2, 3, 0, 1};
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, 1'b1, 2'd0, 1'b1);
            tick();
            checks++;
            if (bus.out_chan !== 2'(want[i]) || bus.out_valid !== 1'b1 || bus.out_data !== m_data) begin
                errors++; $display("FAIL rr_seq[%0d] got c=%0d v=%b d=%h want c=%0d v=1 d=%h",
                                   i, bus.out_chan, bus.out_valid, bus.out_data, want[i], m_data);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held_d;
        logic [1:0]   held_c;
        drive(4'b0001, 1'b0, 2'd0, 1'b1);
        tick();
        held_d = bus.out_data;
        held_c = bus.out_chan;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010, 1'b0, 2'd1, 1'b0);
            #1;
            checks++;
            if (bus.in_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready[%0d] got %b want 0000", i, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_data !== held_d || bus.out_chan !== held_c || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d] got d=%h c=%0d v=%b want d=%h c=%0d v=1",
                                   i, bus.out_data, bus.out_chan, bus.out_valid, held_d, held_c);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release_ready got %b want 0010", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_chan !== 2'd1 || bus.out_data !== bus.in_data[W +: W]) begin
            errors++; $display("FAIL bp_release_out got c=%0d d=%h want 1/%h",
                               bus.out_chan, bus.out_data, bus.in_data[W +: W]);
        end
    endtask

    task automatic test_sparse();
        do_reset(1);
        drive(4'b0010, 1'b0, 2'd1, 1'b1);
        tick();
        drive(4'b0001, 1'b1, 2'd0, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin
            errors++; $display("FAIL sparse_ch0 got %b want 0001", bus.in_ready);
        end
        tick();
        drive(4'b1001, 1'b1, 2'd0, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 4'b1000) begin
            errors++; $display("FAIL sparse_ch3 got %b want 1000", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_chan !== 2'd3) begin
            errors++; $display("FAIL sparse_out got %0d want 3", bus.out_chan);
        end
    endtask

    task automatic test_count();
        logic [15:0] want;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            drive(4'b0001, 1'b0, 2'd0, 1'b1);
            tick();
        end
        drive(4'b0000, 1'b0, 2'd0, 1'b1);
        tick();
`ifdef YMUX_ARB_COUNT_EN
        want = 16'd10;
`else
        want = 16'd0;
`endif
        checks++;
        if (bus.xfer_count !== want) begin
            errors++; $display("FAIL count_ten got %0d want %0d", bus.xfer_count, want);
        end
        drive(4'b0001, 1'b0, 2'd0, 1'b1);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.xfer_count !== 16'd0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL count_reset got cnt=%0d v=%b want 0/0", bus.xfer_count, bus.out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
            reset = ($urandom_range(0, 60) == 0);
            #1;
            checks++;
            if (bus.in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready[%0d] got %b want %b", i, bus.in_ready, exp_ready());
            end
            tick();
            checks++;
            if (bus.out_valid !== m_valid || bus.out_data !== m_data ||
                bus.out_chan !== 2'(m_chan) || bus.xfer_count !== 16'(m_cnt)) begin
                errors++; $display("FAIL rand_out[%0d] got v=%b d=%h c=%0d n=%0d want v=%b d=%h c=%0d n=%0d",
                                   i, bus.out_valid, bus.out_data, bus.out_chan, bus.xfer_count,
                                   m_valid, m_data, m_chan, m_cnt);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_valid = 0; m_data = '0; m_chan = 0; m_lg = N - 1; m_cnt = 0;
        reset   = 1'b1;
        drive(4'b0000, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
